tetris_input_arbiter: RTL and testbench

- Turns the SoC's USB keyboard keycode export (8-bit HID code) and the two board push-buttons into single game commands.
- Delivers commands one at a time over a valid/ready handshake to the Tetris game-logic FSM.
- Handles DAS/auto-repeat for held movement keys, debounces the buttons, and arbitrates between keyboard and buttons.
- Sits between the SoC wrapper outputs and the game core.

---
 rtl/tetris_input_pkg.sv | 53 +++++
 rtl/tetris_input_arbiter_btn_debounce.sv | 53 +++++
 rtl/tetris_input_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tetris_input_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared command codes, HID keycodes and keycode decode for the Tetris input path.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_LEFT    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_ROT_CW  = 3'd3,
    CMD_ROT_CCW = 3'd4,
    CMD_SOFT    = 3'd5,
    CMD_HARD    = 3'd6,
    CMD_PAUSE   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_DAS_WAIT,
    ST_REPEAT
  } kb_state_e;

  localparam logic [7:0] HID_LEFT    = 8'h04;
  localparam logic [7:0] HID_RIGHT   = 8'h07;
  localparam logic [7:0] HID_ROT_CW  = 8'h1A;
  localparam logic [7:0] HID_ROT_CCW = 8'h14;
  localparam logic [7:0] HID_SOFT    = 8'h16;
  localparam logic [7:0] HID_HARD    = 8'h2C;
  localparam logic [7:0] HID_PAUSE   = 8'h13;

  function automatic cmd_e decode_keycode(input logic [7:0] kc);
    cmd_e c;
    case (kc)
      HID_LEFT:    c = CMD_LEFT;
      HID_RIGHT:   c = CMD_RIGHT;
      HID_ROT_CW:  c = CMD_ROT_CW;
      HID_ROT_CCW: c = CMD_ROT_CCW;
      HID_SOFT:    c = CMD_SOFT;
      HID_HARD:    c = CMD_HARD;
      HID_PAUSE:   c = CMD_PAUSE;
      default:     c = CMD_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_repeatable(input cmd_e c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_SOFT);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tetris_input_arbiter_btn_debounce.sv
// tetris_btn_debounce: 2-FF synchronizer, stable-level debounce and one-cycle press pulse
// for a single active-low board button.
module tetris_btn_debounce #(
  parameter int DEBOUNCE = 500000,
  parameter int CNT_W    = 24
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic btn_n,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level matches the debounced one restarts the count.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        db_d    = sync2_q;
        press_d = !sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use <= only; next-state logic sits in always_comb with defaults
  // assigned first, so no latch can be inferred.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tetris_input_arbiter.sv
// tetris_input_arbiter: keyboard DAS/auto-repeat, button debounce and single-slot command
// arbitration. Optional drop counter enabled by TETRIS_INPUT_DROP_CNT_EN.
module tetris_input_arbiter
  import tetris_input_pkg::*;
#(
  parameter int DAS_DELAY  = 8000000,
  parameter int ARR_PERIOD = 2500000,
  parameter int DEBOUNCE   = 500000,
  parameter int CNT_W      = 24
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic [1:0] key_n,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [2:0] held_cmd
`ifdef TETRIS_INPUT_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  logic [7:0]       kc_q;
  cmd_e             dec;
  kb_state_e        state_q, state_d;
  cmd_e             last_q, last_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             kb_press, kb_repeat;
  logic             b0_press, b1_press;
  logic             kb_pend_q, kb_pend_d;
  cmd_e             kb_cmd_q, kb_cmd_d;
  logic             b0_pend_q, b0_pend_d;
  logic             b1_pend_q, b1_pend_d;
  logic             cmd_valid_q, cmd_valid_d;
  cmd_e             cmd_q, cmd_d;

  tetris_btn_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_btn0 (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(key_n[0]), .press(b0_press)
  );

  tetris_btn_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_btn1 (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(key_n[1]), .press(b1_press)
  );

  assign dec = decode_keycode(kc_q);

  // A change to a different nonzero command always restarts as a fresh press.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmr_d     = tmr_q;
    kb_press  = 1'b0;
    kb_repeat = 1'b0;
    if (dec == CMD_NONE) begin
      state_d = ST_IDLE;
      last_d  = CMD_NONE;
    end else if (state_q == ST_IDLE || dec != last_q) begin
      state_d  = ST_HELD;
      last_d   = dec;
      kb_press = 1'b1;
    end else begin
      case (state_q)
        ST_HELD: begin
          if (is_repeatable(dec)) begin
            state_d = ST_DAS_WAIT;
            tmr_d   = CNT_W'(DAS_DELAY - 1);
          end
        end
        ST_DAS_WAIT, ST_REPEAT: begin
          if (tmr_q == '0) begin
            kb_repeat = 1'b1;
            state_d   = ST_REPEAT;
            tmr_d     = CNT_W'(ARR_PERIOD - 1);
          end else begin
            tmr_d = tmr_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The slot reads only registered pends, so a freshly raised pend is seen one cycle later.
  always_comb begin
    kb_pend_d   = kb_pend_q;
    kb_cmd_d    = kb_cmd_q;
    b0_pend_d   = b0_pend_q;
    b1_pend_d   = b1_pend_q;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    if (!cmd_valid_q || cmd_ready) begin
      cmd_valid_d = 1'b1;
      if (kb_pend_q) begin
        cmd_d     = kb_cmd_q;
        kb_pend_d = 1'b0;
      end else if (b0_pend_q) begin
        cmd_d     = CMD_ROT_CW;
        b0_pend_d = 1'b0;
      end else if (b1_pend_q) begin
        cmd_d     = CMD_PAUSE;
        b1_pend_d = 1'b0;
      end else begin
        cmd_valid_d = 1'b0;
      end
    end
    if (kb_press || (kb_repeat && !kb_pend_q)) begin
      kb_pend_d = 1'b1;
      kb_cmd_d  = dec;
    end
    if (b0_press && !b0_pend_q) b0_pend_d = 1'b1;
    if (b1_press && !b1_pend_q) b1_pend_d = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      kc_q        <= '0;
      state_q     <= ST_IDLE;
      last_q      <= CMD_NONE;
      tmr_q       <= '0;
      kb_pend_q   <= 1'b0;
      kb_cmd_q    <= CMD_NONE;
      b0_pend_q   <= 1'b0;
      b1_pend_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      kc_q        <= keycode;
      state_q     <= state_d;
      last_q      <= last_d;
      tmr_q       <= tmr_d;
      kb_pend_q   <= kb_pend_d;
      kb_cmd_q    <= kb_cmd_d;
      b0_pend_q   <= b0_pend_d;
      b1_pend_q   <= b1_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign held_cmd  = (state_q != ST_IDLE) ? dec : CMD_NONE;

`ifdef TETRIS_INPUT_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (kb_repeat && !kb_press && kb_pend_q) drop_d = sat_inc(drop_d);
    if (b0_press && b0_pend_q)               drop_d = sat_inc(drop_d);
    if (b1_press && b1_pend_q)               drop_d = sat_inc(drop_d);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) drop_q <= '0;
    else                drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_tetris_input_arbiter.sv
// Directed bench for tetris_input_arbiter with a cycle-stamped expected-command scoreboard.
module tb_tetris_input_arbiter;
  import tetris_input_pkg::*;

  localparam int DAS = 10;
  localparam int ARR = 4;
  localparam int DB  = 3;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] keycode;
  logic [1:0] key_n;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [2:0] held_cmd;
`ifdef TETRIS_INPUT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk_clk = ~clk_clk;

  tetris_input_arbiter #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR), .DEBOUNCE(DB), .CNT_W(24)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .keycode(keycode),
    .key_n(key_n),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .held_cmd(held_cmd)
`ifdef TETRIS_INPUT_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    cmd_e c;
    int   at;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  logic  rst_at_edge = 1'b0;
  int    errors = 0;
  int    checks = 0;
  string phase = "reset";
  logic  stalled_prev = 1'b0;
  logic [2:0] stall_cmd = 3'd0;

  always @(posedge clk_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset_reset_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // Samples on the falling edge: holds stalled commands steady, pops on every handshake.
  task automatic monitor_step();
    exp_t e;
    if (stalled_prev && rst_at_edge) begin
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_cmd", 32'(cmd), 32'(stall_cmd));
    end
    if (cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s/unexpected_cmd: observed=%0d expected=none", phase, cmd);
      end else begin
        e = sb.pop_front();
        check("cmd", 32'(cmd), 32'(e.c));
        if (e.at >= 0) check("cmd_cycle", 32'(cyc), 32'(e.at));
      end
    end
    stalled_prev = cmd_valid && !cmd_ready;
    stall_cmd    = cmd;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #2;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check("drained", 32'(sb.size()), 32'd0);
  endtask

  // Timing reference: inputs driven right after edge n; a keycode press is seen by the
  // handshake sampler at cycle n+3 (kc_q at n+1, pend at n+2, slot at n+3).
  initial begin
    int n;
    reset_reset_n = 1'b0;
    keycode       = 8'h00;
    key_n         = 2'b11;
    cmd_ready     = 1'b1;
    fork
      forever begin
        @(negedge clk_clk);
        monitor_step();
      end
    join_none
    step(3);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_held", 32'(held_cmd), 32'd0);
`ifdef TETRIS_INPUT_DROP_CNT_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
    reset_reset_n = 1'b1;
    step(2);

    // 1: non-repeating key held long yields exactly one command.
    phase = "t1_rot_cw";
    n = cyc;
    sb.push_back('{CMD_ROT_CW, n + 3});
    keycode = HID_ROT_CW;
    step(5);
    check("held", 32'(held_cmd), 32'(CMD_ROT_CW));
    step(35);
    keycode = 8'h00;
    step(3);
    check("held_release", 32'(held_cmd), 32'd0);
    drain(10);

    // 2: DAS timer starts on entering DAS_WAIT (one cycle after the press), so the first
    // repeat follows the press by DAS+1 cycles, then every ARR cycles while held 30 cycles.
    phase = "t2_left_das";
    n = cyc;
    sb.push_back('{CMD_LEFT, n + 3});
    for (int j = 0; j < 5; j++) sb.push_back('{CMD_LEFT, n + 3 + DAS + 1 + ARR * j});
    keycode = HID_LEFT;
    step(4);
    check("held", 32'(held_cmd), 32'(CMD_LEFT));
    step(26);
    keycode = 8'h00;
    step(3);
    check("held_release", 32'(held_cmd), 32'd0);
    step(12);
    check("no_extra", 32'(sb.size()), 32'd0);

    // 3: stalled slot keeps RIGHT steady; one repeat queues, the other four are dropped.
    phase = "t3_stall";
    cmd_ready = 1'b0;
    n = cyc;
    sb.push_back('{CMD_RIGHT, -1});
    sb.push_back('{CMD_RIGHT, -1});
    keycode = HID_RIGHT;
    step(30);
    keycode = 8'h00;
    step(3);
    check("stall_valid_pre", 32'(cmd_valid), 32'd1);
    check("stall_cmd_pre", 32'(cmd), 32'(CMD_RIGHT));
`ifdef TETRIS_INPUT_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'd4);
`endif
    cmd_ready = 1'b1;
    drain(10);
    step(5);
    check("no_extra", 32'(sb.size()), 32'd0);

    // 4: button 0 bounces 0-1 then settles low; one ROT_CW after the full debounce window.
    phase = "t4_bounce";
    n = cyc;
    sb.push_back('{CMD_ROT_CW, n + 9});
    key_n = 2'b10;
    step(1);
    key_n = 2'b11;
    step(1);
    key_n = 2'b10;
    step(15);
    key_n = 2'b11;
    step(10);
    check("no_extra", 32'(sb.size()), 32'd0);

    // 5: keyboard and button-1 pends land on the same edge; keyboard wins.
    phase = "t5_priority";
    n = cyc;
    sb.push_back('{CMD_HARD, n + 7});
    sb.push_back('{CMD_PAUSE, n + 8});
    key_n = 2'b01;
    step(4);
    keycode = HID_HARD;
    step(10);
    keycode = 8'h00;
    key_n   = 2'b11;
    step(10);
    check("no_extra", 32'(sb.size()), 32'd0);

    // 6: one-cycle reset while a command is stalled discards it; the held key re-presses.
    phase = "t6_reset";
    cmd_ready = 1'b0;
    n = cyc;
    keycode = HID_ROT_CCW;
    step(5);
    check("pre_valid", 32'(cmd_valid), 32'd1);
    check("pre_cmd", 32'(cmd), 32'(CMD_ROT_CCW));
    reset_reset_n = 1'b0;
    step(1);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_held", 32'(held_cmd), 32'd0);
    reset_reset_n = 1'b1;
    cmd_ready     = 1'b1;
    sb.push_back('{CMD_ROT_CCW, n + 9});
    step(15);
    keycode = 8'h00;
    step(5);
    check("no_extra", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
